layer_compositor: RTL and testbench
===================================

Name: layer_compositor

Overview:
- Parametrised successor to the fixed five-cluster priority mux in the GPU top level.
- Composites LAYERS colour streams per pixel: first enabled, non-transparent layer in priority order wins (layer 0 highest).
- Per-layer colour keys, per-layer enables and background colour are set through the register-write port. They are double-buffered and take effect only at frame start.
- Pipelined and clock-enabled. Sync and visible are delayed to match the pixel data. Sits between the cluster array and the VGA pins.

Parameters:
- LAYERS, 5: number of input layers, 1..16.
- COLOR_WIDTH, 12: pixel width; 4:4:4 RGB when 12.
- ADDR_WIDTH, 8: register word-address width.
- DATA_WIDTH, 32: register write-data width.
- DEFAULT_KEY, 12'hFFF: reset key value for every layer.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- waddr  in  ADDR_WIDTH  register word address.
- wdata  in  DATA_WIDTH  register write data.
- wen  in  1  single-cycle write strobe.
- pix_ce  in  1  pixel clock enable (one clk in two at 50 MHz).
- frame_start  in  1  qualified by pix_ce; first pixel of a frame.
- visible_in  in  1  active-video flag.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- layer_pixel  in  LAYERS*COLOR_WIDTH  layer k at bits [k*COLOR_WIDTH +: COLOR_WIDTH].
- pixel_out  out  COLOR_WIDTH  composited colour.
- visible_out  out  1  delayed visible.
- hsync_out  out  1  delayed hsync.
- vsync_out  out  1  delayed vsync.
- commit_pending  out  1  staged config awaiting frame start.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state advances only when pix_ce=1, except register writes.
- Register map (word addresses); writes to unmapped addresses are ignored:
  - 0x00 BG: wdata[COLOR_WIDTH-1:0].
  - 0x01 LAYER_EN: wdata[LAYERS-1:0].
  - 0x02 COMMIT: any write sets commit_pending.
  - 0x10+k KEY[k]: bit 12 key_en, bits [11:0] key colour. Addresses for k>=LAYERS are ignored.
- Writes go to staging registers on the wen cycle, regardless of pix_ce.
- Commit:
  - If commit_pending=1 and pix_ce=1 and frame_start=1, all staging registers copy to active registers in the same cycle, and commit_pending clears.
  - If a COMMIT write coincides with that cycle, pending stays set, so the next frame commits again.
  - A staging write coinciding with the copy cycle: the old staging value is copied and the new value is kept in staging.
- Pipeline: exactly 2 pix_ce beats of latency for pixel, visible, hsync and vsync alike.
  - Stage 1 registers the inputs and computes the opaque vector: opaque[k] = en[k] && !(key_en[k] && pix[k]==key[k]).
  - Stage 2 selects the lowest k with opaque[k]=1. If none is opaque, BG is used. If visible (stage-2 copy) is 0, the output is 0.
  - The active config is sampled in stage 1. A commit therefore affects the pixel entering on the frame_start beat.
- Reset values:
  - pixel_out=0, visible_out=0, hsync_out=1, vsync_out=1, commit_pending=0.
  - BG=0, LAYER_EN all ones, every KEY = {1'b1, DEFAULT_KEY} in both staging and active.
  - Pipeline registers are cleared: sync=1, visible=0.
- Reset mid-frame: outputs return to reset values on the next clk. A pending commit is discarded.
- pix_ce=0: all outputs hold.

Optional Feature:
- Macro: LAYER_COMPOSITOR_BORDER_EN.
- When defined:
  - Adds register 0x03 BORDER: bit 12 enable, bits [11:0] colour.
  - Adds inputs x_in and y_in (16 bits each), pipelined alongside the pixel.
  - While enabled and visible, pixels with x=0, x=639, y=0 or y=479 output the border colour, overriding layers.
  - BORDER is double-buffered like the other registers.
- When undefined: no extra ports, 0x03 is ignored, behaviour as above.

Decomposition:
- Package layer_compositor_pkg holds:
  - register address localparams (REG_BG, REG_LAYER_EN, REG_COMMIT, REG_KEY_BASE, REG_BORDER);
  - typedef key_cfg_t (struct: key_en, key colour);
  - screen dimension constants 640/480.
- One sub-module, compositor_prio_sel: combinational lowest-index priority encoder over the opaque vector plus colour mux, parametrised by LAYERS.

Test Plan:
- After reset, LAYERS=5 with layer0=12'hFFF and layer1=12'h0F0, visible=1, pix_ce every other clk → pixel_out=12'h0F0 exactly 2 pix_ce beats later; hsync/vsync aligned with it.
- All layers 12'hFFF, write BG=12'h123 then COMMIT mid-frame → output stays 0 until frame_start; the frame_start pixel and later ones give 12'h123; commit_pending falls on that beat.
- Write LAYER_EN=5'b11110, commit, layer0=12'hF00, layer1=12'h00F → 12'h00F.
- Write KEY[2]=0x000 with key_en=0, commit; layers 0/1=12'hFFF, layer2=12'hFFF → 12'hFFF (key disabled, layer 2 opaque).
- COMMIT write coincident with the frame_start/pix_ce cycle → commit applied and commit_pending still 1 afterward. rst asserted mid-frame → pixel_out=0, hsync_out=1, commit_pending=0 on the next clk.
- With LAYER_COMPOSITOR_BORDER_EN: BORDER={1,12'hF0F}, commit; x=0 → 12'hF0F; x=1 → normal composite; visible=0 at x=0 → 0.

Source files
------------

// File: rtl/layer_compositor_pkg.sv
// layer_compositor_pkg
// Shared definitions for the layer compositor: register word addresses,
// the per-layer colour-key record and the visible screen dimensions used
// by the optional border overlay.
package layer_compositor_pkg;

    // Register word addresses
    localparam int REG_BG       = 'h00;
    localparam int REG_LAYER_EN = 'h01;
    localparam int REG_COMMIT   = 'h02;
    localparam int REG_BORDER   = 'h03;
    localparam int REG_KEY_BASE = 'h10;

    // Key colour field width and the bit that enables keying in a KEY write
    localparam int KEY_WIDTH   = 12;
    localparam int KEY_EN_BIT  = 12;

    // Visible screen size
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef struct packed {
        logic                 key_en;
        logic [KEY_WIDTH-1:0] color;
    } key_cfg_t;

endpackage

// File: rtl/compositor_prio_sel.sv
// compositor_prio_sel
// Combinational lowest-index priority encoder over the opaque vector plus
// the matching colour mux. Layer 0 has the highest priority.
// Ports:
//   opaque     in  LAYERS              per-layer opaque flags
//   pix        in  LAYERS*COLOR_WIDTH  packed layer colours, layer k at [k*CW +: CW]
//   any_opaque out 1                   at least one layer is opaque
//   sel_pix    out COLOR_WIDTH         colour of the winning layer (0 if none)
module compositor_prio_sel #(
    parameter int LAYERS      = 5,
    parameter int COLOR_WIDTH = 12
) (
    input  logic [LAYERS-1:0]             opaque,
    input  logic [LAYERS*COLOR_WIDTH-1:0] pix,
    output logic                          any_opaque,
    output logic [COLOR_WIDTH-1:0]        sel_pix
);

    // Walk from the lowest priority upward so the last hit is the lowest index
    always_comb begin
        any_opaque = 1'b0;
        sel_pix    = '0;
        for (int k = LAYERS - 1; k >= 0; k--) begin
            if (opaque[k]) begin
                any_opaque = 1'b1;
                sel_pix    = pix[k*COLOR_WIDTH +: COLOR_WIDTH];
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// layer_compositor
// Composites LAYERS colour streams per pixel: the first enabled layer whose
// colour does not match its colour key wins, otherwise the background colour.
// Configuration is written into staging registers and copied to the active
// set on the first pixel of a frame after a COMMIT. Two pix_ce beats of
// latency for pixel, visible and syncs.
// Optional feature macro: LAYER_COMPOSITOR_BORDER_EN (border overlay with
// x_in/y_in inputs and register 0x03).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   waddr, wdata, wen         register write port (independent of pix_ce)
//   pix_ce                    pixel clock enable
//   frame_start               first pixel of a frame (qualified by pix_ce)
//   visible_in, hsync_in, vsync_in   video timing in
//   x_in, y_in                pixel coordinates (border build only)
//   layer_pixel               packed layer colours
//   pixel_out, visible_out, hsync_out, vsync_out   delayed video out
//   commit_pending            staged config waiting for frame start
module layer_compositor
    import layer_compositor_pkg::*;
#(
    parameter int             LAYERS      = 5,
    parameter int             COLOR_WIDTH = 12,
    parameter int             ADDR_WIDTH  = 8,
    parameter int             DATA_WIDTH  = 32,
    parameter logic [11:0]    DEFAULT_KEY = 12'hFFF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          wen,
    input  logic                          pix_ce,
    input  logic                          frame_start,
    input  logic                          visible_in,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
`ifdef LAYER_COMPOSITOR_BORDER_EN
    input  logic [15:0]                   x_in,
    input  logic [15:0]                   y_in,
`endif
    input  logic [LAYERS*COLOR_WIDTH-1:0] layer_pixel,
    output logic [COLOR_WIDTH-1:0]        pixel_out,
    output logic                          visible_out,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic                          commit_pending
);

    localparam key_cfg_t KEY_RST = '{key_en: 1'b1, color: DEFAULT_KEY};

    logic [COLOR_WIDTH-1:0] stg_bg_q, stg_bg_d, act_bg_q, act_bg_d;
    logic [LAYERS-1:0]      stg_en_q, stg_en_d, act_en_q, act_en_d;
    key_cfg_t               stg_key_q [LAYERS];
    key_cfg_t               stg_key_d [LAYERS];
    key_cfg_t               act_key_q [LAYERS];
    key_cfg_t               act_key_d [LAYERS];
    logic                   pending_q, pending_d;
    logic                   commit_now;

    logic [LAYERS*COLOR_WIDTH-1:0] s1_pix_q, s1_pix_d;
    logic [LAYERS-1:0]             s1_opaque_q, s1_opaque_d;
    logic [COLOR_WIDTH-1:0]        s1_bg_q, s1_bg_d;
    logic                          s1_vis_q, s1_vis_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic [COLOR_WIDTH-1:0]        pix_out_q, pix_out_d;
    logic                          vis_out_q, vis_out_d, hs_out_q, hs_out_d, vs_out_q, vs_out_d;

    logic                          any_opaque;
    logic [COLOR_WIDTH-1:0]        sel_pix;
    logic                          unused_wdata;

`ifdef LAYER_COMPOSITOR_BORDER_EN
    key_cfg_t stg_border_q, stg_border_d, act_border_q, act_border_d;
    logic     s1_border_q, s1_border_d;
`endif

    assign unused_wdata = ^wdata;
    assign commit_now   = pending_q && pix_ce && frame_start;

    // Register writes land in staging; a COMMIT write wins over the clear so
    // a commit arriving on the copy cycle schedules another one next frame.
    always_comb begin
        stg_bg_d  = stg_bg_q;
        stg_en_d  = stg_en_q;
        stg_key_d = stg_key_q;
        pending_d = pending_q;
`ifdef LAYER_COMPOSITOR_BORDER_EN
        stg_border_d = stg_border_q;
`endif
        if (commit_now) begin
            pending_d = 1'b0;
        end
        if (wen) begin
            if (waddr == ADDR_WIDTH'(REG_BG))       stg_bg_d  = wdata[COLOR_WIDTH-1:0];
            if (waddr == ADDR_WIDTH'(REG_LAYER_EN)) stg_en_d  = wdata[LAYERS-1:0];
            if (waddr == ADDR_WIDTH'(REG_COMMIT))   pending_d = 1'b1;
`ifdef LAYER_COMPOSITOR_BORDER_EN
            if (waddr == ADDR_WIDTH'(REG_BORDER))
                stg_border_d = '{key_en: wdata[KEY_EN_BIT], color: wdata[KEY_WIDTH-1:0]};
`endif
            for (int k = 0; k < LAYERS; k++) begin
                if (waddr == ADDR_WIDTH'(REG_KEY_BASE + k))
                    stg_key_d[k] = '{key_en: wdata[KEY_EN_BIT], color: wdata[KEY_WIDTH-1:0]};
            end
        end
    end

    // Active set copies the pre-write staging values on the commit beat
    always_comb begin
        act_bg_d  = commit_now ? stg_bg_q  : act_bg_q;
        act_en_d  = commit_now ? stg_en_q  : act_en_q;
        act_key_d = commit_now ? stg_key_q : act_key_q;
`ifdef LAYER_COMPOSITOR_BORDER_EN
        act_border_d = commit_now ? stg_border_q : act_border_q;
`endif
    end

    // Stage 1 uses the next active config so the frame_start pixel already
    // sees a freshly committed configuration.
    always_comb begin
        s1_pix_d    = s1_pix_q;
        s1_opaque_d = s1_opaque_q;
        s1_bg_d     = s1_bg_q;
        s1_vis_d    = s1_vis_q;
        s1_hs_d     = s1_hs_q;
        s1_vs_d     = s1_vs_q;
`ifdef LAYER_COMPOSITOR_BORDER_EN
        s1_border_d = s1_border_q;
`endif
        if (pix_ce) begin
            s1_pix_d = layer_pixel;
            s1_bg_d  = act_bg_d;
            s1_vis_d = visible_in;
            s1_hs_d  = hsync_in;
            s1_vs_d  = vsync_in;
            for (int k = 0; k < LAYERS; k++) begin
                s1_opaque_d[k] = act_en_d[k] &&
                    !(act_key_d[k].key_en &&
                      layer_pixel[k*COLOR_WIDTH +: COLOR_WIDTH] == COLOR_WIDTH'(act_key_d[k].color));
            end
`ifdef LAYER_COMPOSITOR_BORDER_EN
            s1_border_d = act_border_d.key_en &&
                (x_in == 16'd0 || x_in == 16'(SCREEN_W - 1) ||
                 y_in == 16'd0 || y_in == 16'(SCREEN_H - 1));
`endif
        end
    end

    compositor_prio_sel #(
        .LAYERS      (LAYERS),
        .COLOR_WIDTH (COLOR_WIDTH)
    ) u_prio_sel (
        .opaque     (s1_opaque_q),
        .pix        (s1_pix_q),
        .any_opaque (any_opaque),
        .sel_pix    (sel_pix)
    );

    // Stage 2: pick winner or background, blank outside active video
    always_comb begin
        pix_out_d = pix_out_q;
        vis_out_d = vis_out_q;
        hs_out_d  = hs_out_q;
        vs_out_d  = vs_out_q;
        if (pix_ce) begin
            vis_out_d = s1_vis_q;
            hs_out_d  = s1_hs_q;
            vs_out_d  = s1_vs_q;
            if (!s1_vis_q)
                pix_out_d = '0;
`ifdef LAYER_COMPOSITOR_BORDER_EN
            else if (s1_border_q)
                pix_out_d = COLOR_WIDTH'(act_border_q.color);
`endif
            else if (any_opaque)
                pix_out_d = sel_pix;
            else
                pix_out_d = s1_bg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_bg_q    <= '0;
            act_bg_q    <= '0;
            stg_en_q    <= '1;
            act_en_q    <= '1;
            for (int k = 0; k < LAYERS; k++) begin
                stg_key_q[k] <= KEY_RST;
                act_key_q[k] <= KEY_RST;
            end
            pending_q   <= 1'b0;
            s1_pix_q    <= '0;
            s1_opaque_q <= '0;
            s1_bg_q     <= '0;
            s1_vis_q    <= 1'b0;
            s1_hs_q     <= 1'b1;
            s1_vs_q     <= 1'b1;
            pix_out_q   <= '0;
            vis_out_q   <= 1'b0;
            hs_out_q    <= 1'b1;
            vs_out_q    <= 1'b1;
`ifdef LAYER_COMPOSITOR_BORDER_EN
            stg_border_q <= '0;
            act_border_q <= '0;
            s1_border_q  <= 1'b0;
`endif
        end else begin
            stg_bg_q    <= stg_bg_d;
            act_bg_q    <= act_bg_d;
            stg_en_q    <= stg_en_d;
            act_en_q    <= act_en_d;
            stg_key_q   <= stg_key_d;
            act_key_q   <= act_key_d;
            pending_q   <= pending_d;
            s1_pix_q    <= s1_pix_d;
            s1_opaque_q <= s1_opaque_d;
            s1_bg_q     <= s1_bg_d;
            s1_vis_q    <= s1_vis_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            pix_out_q   <= pix_out_d;
            vis_out_q   <= vis_out_d;
            hs_out_q    <= hs_out_d;
            vs_out_q    <= vs_out_d;
`ifdef LAYER_COMPOSITOR_BORDER_EN
            stg_border_q <= stg_border_d;
            act_border_q <= act_border_d;
            s1_border_q  <= s1_border_d;
`endif
        end
    end

    assign pixel_out      = pix_out_q;
    assign visible_out    = vis_out_q;
    assign hsync_out      = hs_out_q;
    assign vsync_out      = vs_out_q;
    assign commit_pending = pending_q;

endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor
// Directed self-checking bench for layer_compositor with LAYERS=5, 12-bit
// colour. pix_ce is high one clk in two; every beat task starts and ends
// on a falling edge so outputs are sampled away from the rising edge.
module tb_layer_compositor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        wen = 1'b0;
    logic        pix_ce = 1'b0;
    logic        frame_start = 1'b0;
    logic        visible_in = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [15:0] x_in = 16'd100;
    logic [15:0] y_in = 16'd100;
    logic [59:0] layer_pixel = '0;
    logic [11:0] pixel_out;
    logic        visible_out, hsync_out, vsync_out, commit_pending;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    layer_compositor dut (
        .clk            (clk),
        .rst            (rst),
        .waddr          (waddr),
        .wdata          (wdata),
        .wen            (wen),
        .pix_ce         (pix_ce),
        .frame_start    (frame_start),
        .visible_in     (visible_in),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
`ifdef LAYER_COMPOSITOR_BORDER_EN
        .x_in           (x_in),
        .y_in           (y_in),
`endif
        .layer_pixel    (layer_pixel),
        .pixel_out      (pixel_out),
        .visible_out    (visible_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .commit_pending (commit_pending)
    );

    function automatic logic [59:0] pack(input logic [11:0] l0, l1, l2, l3, l4);
        return {l4, l3, l2, l1, l0};
    endfunction

    // One pix_ce beat followed by one idle clk; optional write on the beat
    task automatic beat(input logic fs, input logic vis, input logic hs, input logic vs,
                        input logic [59:0] pix, input logic w, input logic [7:0] a,
                        input logic [31:0] d);
        pix_ce = 1'b1; frame_start = fs; visible_in = vis; hsync_in = hs; vsync_in = vs;
        layer_pixel = pix; wen = w; waddr = a; wdata = d;
        @(negedge clk);
        pix_ce = 1'b0; frame_start = 1'b0; wen = 1'b0;
        @(negedge clk);
    endtask

    task automatic px(input logic fs, input logic [59:0] pix);
        beat(fs, 1'b1, 1'b1, 1'b1, pix, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (pixel_out !== 12'h000) begin tests_failed++; $display("[TB] FAIL reset_pixel got %h want 000", pixel_out); end
        tests_run++;
        if (visible_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_visible got %b want 0", visible_out); end
        tests_run++;
        if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_sync got %b%b want 11", hsync_out, vsync_out); end
        tests_run++;
        if (commit_pending !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pending got %b want 0", commit_pending); end
    endtask

    task automatic test_basic_composite;
        beat(1'b0, 1'b1, 1'b0, 1'b1, pack(12'hFFF, 12'h0F0, 12'h000, 12'h000, 12'h000), 1'b0, 8'h00, 32'h0);
        tests_run++;
        if (pixel_out !== 12'h000 || hsync_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL latency_early got %h hs=%b want 000 hs=1", pixel_out, hsync_out); end
        beat(1'b0, 1'b1, 1'b1, 1'b0, pack(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF), 1'b0, 8'h00, 32'h0);
        tests_run++;
        if (pixel_out !== 12'h0F0) begin tests_failed++; $display("[TB] FAIL basic_pixel got %h want 0f0", pixel_out); end
        tests_run++;
        if (hsync_out !== 1'b0 || vsync_out !== 1'b1 || visible_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_sync got hs=%b vs=%b vis=%b want 0 1 1", hsync_out, vsync_out, visible_out); end
        beat(1'b0, 1'b0, 1'b1, 1'b1, pack(12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0), 1'b0, 8'h00, 32'h0);
        tests_run++;
        if (pixel_out !== 12'h000 || hsync_out !== 1'b1 || vsync_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL all_keyed got %h hs=%b vs=%b want 000 1 0", pixel_out, hsync_out, vsync_out); end
        beat(1'b0, 1'b1, 1'b1, 1'b1, pack(12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0), 1'b0, 8'h00, 32'h0);
        tests_run++;
        if (pixel_out !== 12'h000 || visible_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL blank_invisible got %h vis=%b want 000 0", pixel_out, visible_out); end
    endtask

    task automatic test_bg_commit;
        logic [59:0] all_f;
        all_f = pack(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        write_reg(8'h00, 32'h123);
        write_reg(8'h02, 32'h0);
        tests_run++;
        if (commit_pending !== 1'b1) begin tests_failed++; $display("[TB] FAIL pending_set got %b want 1", commit_pending); end
        px(1'b0, all_f);
        px(1'b0, all_f);
        tests_run++;
        if (pixel_out !== 12'h000) begin tests_failed++; $display("[TB] FAIL bg_before_commit got %h want 000", pixel_out); end
        px(1'b1, all_f);
        tests_run++;
        if (commit_pending !== 1'b0) begin tests_failed++; $display("[TB] FAIL pending_clear got %b want 0", commit_pending); end
        px(1'b0, all_f);
        tests_run++;
        if (pixel_out !== 12'h123) begin tests_failed++; $display("[TB] FAIL bg_frame_start got %h want 123", pixel_out); end
        px(1'b0, all_f);
        tests_run++;
        if (pixel_out !== 12'h123) begin tests_failed++; $display("[TB] FAIL bg_after got %h want 123", pixel_out); end
    endtask

    task automatic test_layer_enable;
        write_reg(8'h01, 32'h1E);
        write_reg(8'h02, 32'h0);
        px(1'b1, pack(12'hF00, 12'h00F, 12'h000, 12'h000, 12'h000));
        px(1'b0, pack(12'hF00, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF));
        tests_run++;
        if (pixel_out !== 12'h00F) begin tests_failed++; $display("[TB] FAIL layer_en got %h want 00f", pixel_out); end
        px(1'b0, pack(12'hF00, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF));
        tests_run++;
        if (pixel_out !== 12'h123) begin tests_failed++; $display("[TB] FAIL disabled_to_bg got %h want 123", pixel_out); end
    endtask

    task automatic test_key_disable;
        write_reg(8'h12, 32'h0000);
        write_reg(8'h02, 32'h0);
        px(1'b1, pack(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF));
        px(1'b0, pack(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF));
        tests_run++;
        if (pixel_out !== 12'hFFF) begin tests_failed++; $display("[TB] FAIL key_disabled got %h want fff", pixel_out); end
    endtask

    task automatic test_commit_coincide;
        logic [59:0] all_f;
        all_f = pack(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        write_reg(8'h00, 32'h456);
        write_reg(8'h01, 32'h01);
        write_reg(8'h02, 32'h0);
        beat(1'b1, 1'b1, 1'b1, 1'b1, all_f, 1'b1, 8'h02, 32'h0);
        tests_run++;
        if (commit_pending !== 1'b1) begin tests_failed++; $display("[TB] FAIL pending_recommit got %b want 1", commit_pending); end
        write_reg(8'h00, 32'h789);
        px(1'b0, all_f);
        tests_run++;
        if (pixel_out !== 12'h456) begin tests_failed++; $display("[TB] FAIL coincide_applied got %h want 456", pixel_out); end
        px(1'b1, all_f);
        px(1'b0, all_f);
        tests_run++;
        if (pixel_out !== 12'h789 || commit_pending !== 1'b0) begin tests_failed++; $display("[TB] FAIL second_commit got %h pend=%b want 789 0", pixel_out, commit_pending); end
    endtask

    task automatic test_unmapped_and_reset;
        logic [59:0] all_f;
        all_f = pack(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        write_reg(8'h02, 32'h0);
        beat(1'b0, 1'b1, 1'b0, 1'b0, all_f, 1'b0, 8'h00, 32'h0);
        beat(1'b0, 1'b1, 1'b0, 1'b0, all_f, 1'b0, 8'h00, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (pixel_out !== 12'h000 || hsync_out !== 1'b1 || vsync_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL midframe_reset got %h hs=%b vs=%b want 000 1 1", pixel_out, hsync_out, vsync_out); end
        tests_run++;
        if (commit_pending !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_discards_commit got %b want 0", commit_pending); end
        // Unmapped writes and an out-of-range key slot must not change config
        write_reg(8'h04, 32'h0000_0ABC);
        write_reg(8'h15, 32'h0000_0000);
`ifndef LAYER_COMPOSITOR_BORDER_EN
        write_reg(8'h03, 32'h0000_1F0F);
`endif
        write_reg(8'h02, 32'h0);
        px(1'b1, pack(12'hFFF, 12'h0F0, 12'h000, 12'h000, 12'h000));
        px(1'b0, all_f);
        tests_run++;
        if (pixel_out !== 12'h0F0) begin tests_failed++; $display("[TB] FAIL config_after_reset got %h want 0f0", pixel_out); end
        px(1'b0, all_f);
        tests_run++;
        if (pixel_out !== 12'h000) begin tests_failed++; $display("[TB] FAIL unmapped_ignored got %h want 000", pixel_out); end
    endtask

`ifdef LAYER_COMPOSITOR_BORDER_EN
    task automatic test_border;
        logic [59:0] p;
        p = pack(12'hFFF, 12'h0F0, 12'h000, 12'h000, 12'h000);
        write_reg(8'h03, 32'h0000_1F0F);
        write_reg(8'h02, 32'h0);
        x_in = 16'd0;
        px(1'b1, p);
        x_in = 16'd1;
        px(1'b0, p);
        tests_run++;
        if (pixel_out !== 12'hF0F) begin tests_failed++; $display("[TB] FAIL border_x0 got %h want f0f", pixel_out); end
        x_in = 16'd0;
        beat(1'b0, 1'b0, 1'b1, 1'b1, p, 1'b0, 8'h00, 32'h0);
        tests_run++;
        if (pixel_out !== 12'h0F0) begin tests_failed++; $display("[TB] FAIL border_x1 got %h want 0f0", pixel_out); end
        px(1'b0, p);
        tests_run++;
        if (pixel_out !== 12'h000) begin tests_failed++; $display("[TB] FAIL border_invisible got %h want 000", pixel_out); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset;
        test_basic_composite;
        test_bg_commit;
        test_layer_enable;
        test_key_disable;
        test_commit_coincide;
        test_unmapped_and_reset;
`ifdef LAYER_COMPOSITOR_BORDER_EN
        test_border;
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
